// File: rtl/motor_ramp_ctrl.sv
// motor_ramp_ctrl
//   Ramps a 2-bit motor speed code toward a commanded target, one step every
//   RAMP_DIV clocks. A direction change is done by ramping to zero, holding
//   zero for DWELL_CYCLES clocks, switching direction, then ramping back up.
//
//   Optional feature: define MOTOR_ESTOP_EN to add the estop input. Estop
//   forces speed 0 immediately and parks the controller in DWELL (uncounted
//   while estop is high), after which it returns to IDLE.
//
// Ports
//   clock      in   system clock, posedge
//   reset      in   asynchronous, active-high reset
//   estop      in   emergency stop (only with MOTOR_ESTOP_EN)
//   cmd_valid  in   command request
//   cmd_speed  in   [1:0] target speed code 0..3
//   cmd_dir    in   target direction, 0 fwd / 1 rev
//   cmd_ready  out  command is accepted when cmd_valid && cmd_ready
//   speed      out  [1:0] registered speed code
//   dir        out  registered direction
//   busy       out  high outside IDLE and HOLD
module motor_ramp_ctrl #(
   parameter logic [15:0] RAMP_DIV     = 16'd1000,
   parameter logic [15:0] DWELL_CYCLES = 16'd5000
) (
   input  logic       clock,
   input  logic       reset,
`ifdef MOTOR_ESTOP_EN
   input  logic       estop,
`endif
   input  logic       cmd_valid,
   input  logic [1:0] cmd_speed,
   input  logic       cmd_dir,
   output logic       cmd_ready,
   output logic [1:0] speed,
   output logic       dir,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RAMP_UP   = 3'd1,
      RAMP_DOWN = 3'd2,
      DWELL     = 3'd3,
      HOLD      = 3'd4
   } state_t;

   localparam logic [15:0] RAMP_LAST  = RAMP_DIV - 16'd1;
   localparam logic [15:0] DWELL_LAST = DWELL_CYCLES - 16'd1;

   state_t      state_q, state_d;
   logic [1:0]  speed_q, speed_d;
   logic        dir_q, dir_d;
   logic [1:0]  tgt_speed_q, tgt_speed_d;
   logic        tgt_dir_q, tgt_dir_d;
   logic        rev_q, rev_d;
   // Shared by the ramp step timer and the dwell timer; the two never run
   // at the same time.
   logic [15:0] cnt_q, cnt_d;
   logic        idle_or_hold;
   logic        accept;

   assign idle_or_hold = (state_q == IDLE) || (state_q == HOLD);
`ifdef MOTOR_ESTOP_EN
   assign cmd_ready = idle_or_hold && !estop;
`else
   assign cmd_ready = idle_or_hold;
`endif
   assign accept = cmd_valid && cmd_ready;
   assign busy   = !idle_or_hold;
   assign speed  = speed_q;
   assign dir    = dir_q;

   always_comb begin
      state_d     = state_q;
      speed_d     = speed_q;
      dir_d       = dir_q;
      tgt_speed_d = tgt_speed_q;
      tgt_dir_d   = tgt_dir_q;
      rev_d       = rev_q;
      // Counter clears unless a branch explicitly keeps counting, so every
      // state change and every speed step restarts it from zero.
      cnt_d       = 16'd0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               tgt_speed_d = cmd_speed;
               tgt_dir_d   = cmd_dir;
               dir_d       = cmd_dir;   // speed is 0 here, safe to switch
               if (cmd_speed != 2'd0) state_d = RAMP_UP;
            end
         end

         HOLD: begin
            if (accept) begin
               tgt_speed_d = cmd_speed;
               tgt_dir_d   = cmd_dir;
               if (cmd_dir != dir_q) begin
                  // Reversal: ramp all the way to 0, the new target is
                  // applied after the dwell.
                  rev_d   = 1'b1;
                  state_d = RAMP_DOWN;
               end else if (cmd_speed > speed_q) begin
                  state_d = RAMP_UP;
               end else if (cmd_speed < speed_q) begin
                  state_d = RAMP_DOWN;
               end
            end
         end

         RAMP_UP: begin
            if (speed_q >= tgt_speed_q) begin
               // Defensive: nothing left to climb.
               state_d = (speed_q == 2'd0) ? IDLE : HOLD;
            end else if (cnt_q == RAMP_LAST) begin
               speed_d = speed_q + 2'd1;
               if (speed_d == tgt_speed_q) state_d = HOLD;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end

         RAMP_DOWN: begin
            if (speed_q == 2'd0) begin
               // Defensive: never decrement below zero.
               state_d = rev_q ? DWELL : IDLE;
            end else if (cnt_q == RAMP_LAST) begin
               speed_d = speed_q - 2'd1;
               if (rev_q) begin
                  if (speed_d == 2'd0) state_d = DWELL;
               end else if (speed_d <= tgt_speed_q) begin
                  state_d = (speed_d == 2'd0) ? IDLE : HOLD;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end

         DWELL: begin
            if (cnt_q == DWELL_LAST) begin
               dir_d   = tgt_dir_q;
               rev_d   = 1'b0;
               state_d = (tgt_speed_q != 2'd0) ? RAMP_UP : IDLE;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end

         default: state_d = IDLE;
      endcase

`ifdef MOTOR_ESTOP_EN
      // Estop overrides everything; the dwell timer is held at zero until
      // estop drops. Direction is kept so the dwell exit does not flip it.
      if (estop) begin
         state_d     = DWELL;
         speed_d     = 2'd0;
         tgt_speed_d = 2'd0;
         tgt_dir_d   = dir_q;
         dir_d       = dir_q;
         rev_d       = 1'b0;
         cnt_d       = 16'd0;
      end
`endif
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         speed_q     <= 2'd0;
         dir_q       <= 1'b0;
         tgt_speed_q <= 2'd0;
         tgt_dir_q   <= 1'b0;
         rev_q       <= 1'b0;
         cnt_q       <= 16'd0;
      end else begin
         state_q     <= state_d;
         speed_q     <= speed_d;
         dir_q       <= dir_d;
         tgt_speed_q <= tgt_speed_d;
         tgt_dir_q   <= tgt_dir_d;
         rev_q       <= rev_d;
         cnt_q       <= cnt_d;
      end
   end

endmodule

// File: doc/motor_ramp_ctrl.md
MOTOR_RAMP_CTRL -- requirements
Module: motor_ramp_ctrl

Interface
REQ-001 SHALL have parameter RAMP_DIV, default 16'd1000, meaning clocks per one-step speed change (legal range 1..65535).
REQ-002 SHALL have parameter DWELL_CYCLES, default 16'd5000, meaning clocks at zero speed before a direction reversal (legal range 1..65535).
REQ-003 SHALL have port clock  input  1  single system clock, all logic on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  input  1  command request.
REQ-006 SHALL have port cmd_speed  input  2  target speed code, 0..3, matching the pwm generator speed encoding.
REQ-007 SHALL have port cmd_dir  input  1  target direction, 0 fwd / 1 rev.
REQ-008 SHALL have port cmd_ready  output  1  command accepted this cycle when cmd_valid and cmd_ready are both 1.
REQ-009 SHALL have port speed  output  2  registered speed code to the pwm generator.
REQ-010 SHALL have port dir  output  1  registered direction to the motor driver.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE and HOLD.

Function
REQ-012 SHALL implement states IDLE, RAMP_UP, RAMP_DOWN, DWELL, HOLD. cmd_ready = 1 only in IDLE and HOLD.
REQ-013 On accept, SHALL latch tgt_speed<=cmd_speed and tgt_dir<=cmd_dir. In other states, cmd_valid is ignored.
REQ-014 IDLE accept: tgt_speed=0 -> dir<=cmd_dir, stay IDLE. Otherwise dir<=cmd_dir, go to RAMP_UP.
REQ-015 HOLD accept, cmd_dir==dir: tgt>speed -> RAMP_UP; tgt<speed -> RAMP_DOWN; equal -> stay HOLD, no change.
REQ-016 HOLD accept, cmd_dir!=dir: go to RAMP_DOWN with a reversal pending. Target 0 is used for the ramp-down.
REQ-017 Step-counter behaviour:
- a 16-bit step counter SHALL clear on every entry to RAMP_UP/RAMP_DOWN and increment each clock in those states;
- when it equals RAMP_DIV-1, speed SHALL change by exactly +/-1 and the counter SHALL clear.
- The first step therefore occurs on the RAMP_DIV-th clock after entry.
REQ-018 RAMP_UP: after the step that makes speed==tgt_speed, SHALL go to HOLD. speed SHALL never exceed 3.
REQ-019 RAMP_DOWN end conditions:
- at speed==0 with reversal pending -> DWELL;
- at speed==tgt_speed with no reversal -> HOLD, or IDLE if speed==0.
- speed SHALL never wrap below 0.
REQ-020 DWELL: speed SHALL be held at 0 for exactly DWELL_CYCLES clocks. Then:
- dir<=tgt_dir and the reversal flag clears;
- tgt_speed>0 -> RAMP_UP, else -> IDLE.
REQ-021 dir SHALL change only while speed==0, in IDLE or at DWELL exit.
REQ-022 HOLD with speed==0 SHALL NOT exist; any path reaching speed 0 without a pending reversal SHALL enter IDLE.

Reset
REQ-023 On reset assertion, SHALL asynchronously force:
- state=IDLE, speed=0, dir=0, busy=0;
- tgt_speed=0, tgt_dir=0;
- counters=0, reversal flag=0.
cmd_ready=1 on the first cycle after deassertion.
REQ-024 Reset mid-ramp or mid-dwell SHALL abandon the operation with no residual step on release.

Configuration
REQ-025 Macro MOTOR_ESTOP_EN defined:
- an input port estop (1 bit) SHALL exist;
- estop high SHALL force speed=0 and tgt_speed=0 on the next clock and enter DWELL;
- cmd_ready SHALL be 0 while estop is high, and DWELL SHALL not count until estop is low;
- DWELL exit SHALL then go to IDLE.
REQ-026 Macro MOTOR_ESTOP_EN undefined: the estop port and all its logic SHALL be absent. Behaviour SHALL be exactly REQ-012..REQ-024.

Verification (RAMP_DIV=4, DWELL_CYCLES=8)
REQ-027 Reset, then accept speed=3, dir=0 from IDLE -> speed 1,2,3 at clocks 4,8,12 after accept, then HOLD, busy=0, cmd_ready=1.
REQ-028 From HOLD speed=3 dir=0, accept speed=1 dir=0 -> speed 2 at +4, 1 at +8, then HOLD, dir constant 0.
REQ-029 From HOLD speed=2 dir=0, accept speed=2 dir=1:
- speed 1 at +4, 0 at +8;
- 8 clocks DWELL at 0;
- dir=1, then speed 1 and 2 in 4-clock steps;
- dir never toggles while speed!=0.
REQ-030 Assert cmd_valid with speed=0 during RAMP_UP -> ignored; ramp completes to the original target.
REQ-031 Assert reset asynchronously mid-RAMP_UP at speed=2 -> speed=0, state IDLE immediately; no step after release.
REQ-032 With MOTOR_ESTOP_EN, estop=1 at HOLD speed=3 -> speed=0 next clock, cmd_ready=0; estop low for 8 clocks -> IDLE, cmd_ready=1.
